cpu_writeback_arbiter: RTL

Shares the single register-file write port between the execute unit and the memory-load unit using round-robin valid/ready arbitration. Registers the winning write onto the register-file write port. Maintains a 16-entry busy scoreboard so decode can stall on registers with a pending write. Sits between the execute/memory stages and the register file write inputs (write enable, write index, write value).

---
 rtl/cpu_writeback_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/cpu_writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port between execute and
// load writebacks, with a registered write stage and a pending-write scoreboard.
module cpu_writeback_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int DATA_W   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ex_valid_i,
  output logic                ex_ready_o,
  input  logic [IDX_W-1:0]    ex_index_i,
  input  logic [DATA_W-1:0]   ex_value_i,
  input  logic                mem_valid_i,
  output logic                mem_ready_o,
  input  logic [IDX_W-1:0]    mem_index_i,
  input  logic [DATA_W-1:0]   mem_value_i,
  input  logic                issue_i,
  input  logic [IDX_W-1:0]    issue_index_i,
  output logic                write_enable_o,
  output logic [IDX_W-1:0]    reg_write_index_o,
  output logic [DATA_W-1:0]   value_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                waw_err_o
);

  typedef enum logic {
    GRANT_EX  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  grant_t                last_grant_q;
  logic                  ex_xfer;
  logic                  mem_xfer;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  clear_hits_issue;
  logic                  waw_hit;

  // Ready depends only on the two valids and the previous winner.
  always_comb begin
    ex_ready_o  = ex_valid_i  && (!mem_valid_i || (last_grant_q == GRANT_MEM));
    mem_ready_o = mem_valid_i && (!ex_valid_i  || (last_grant_q == GRANT_EX));
    ex_xfer     = ex_valid_i  && ex_ready_o;
    mem_xfer    = mem_valid_i && mem_ready_o;
  end

  // Clear applies first so a same-edge issue to the committing register wins.
  always_comb begin
    busy_d = busy_o;
    if (write_enable_o) begin
      busy_d[reg_write_index_o] = 1'b0;
    end
    if (issue_i) begin
      busy_d[issue_index_i] = 1'b1;
    end
    clear_hits_issue = write_enable_o && (reg_write_index_o == issue_index_i);
    waw_hit          = issue_i && busy_o[issue_index_i] && !clear_hits_issue;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q      <= GRANT_MEM;
      write_enable_o    <= 1'b0;
      reg_write_index_o <= '0;
      value_o           <= '0;
      busy_o            <= '0;
      waw_err_o         <= 1'b0;
    end else begin
      write_enable_o <= ex_xfer || mem_xfer;
      if (ex_xfer) begin
        last_grant_q      <= GRANT_EX;
        reg_write_index_o <= ex_index_i;
        value_o           <= ex_value_i;
      end else if (mem_xfer) begin
        last_grant_q      <= GRANT_MEM;
        reg_write_index_o <= mem_index_i;
        value_o           <= mem_value_i;
      end
      busy_o <= busy_d;
      if (waw_hit) begin
        waw_err_o <= 1'b1;
      end
    end
  end

endmodule
